// File: rtl/bmu_pkg.sv
// Shared definitions for the bit-manipulation unit.
// Holds the 5-bit BMU opcode encodings, the multi-cycle FSM state type and a
// helper that tells which opcodes iterate over the operand bits.
package bmu_pkg;

  typedef enum logic [4:0] {
    OP_CLMUL  = 5'b00001,
    OP_CLMULH = 5'b00010,
    OP_CLMULR = 5'b00011,
    OP_CLZ    = 5'b00100,
    OP_CPOP   = 5'b00101,
    OP_CTZ    = 5'b00110
  } bmu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bmu_state_e;

  // Opcodes that walk the operand bits; anything else finishes immediately.
  function automatic logic bmu_op_iterates(input logic [4:0] op);
    return op inside {OP_CLMUL, OP_CLMULH, OP_CLMULR, OP_CLZ, OP_CPOP, OP_CTZ};
  endfunction

endpackage

// File: rtl/bmu_mc_step.sv
// One iteration of the multi-cycle BMU: folds BITS_PER_CYCLE bits of op_a
// (starting at absolute bit position base_i) into the accumulators.
// Ports:
//   option_i  - latched opcode
//   a_slice_i - op_a bits [base_i +: BITS_PER_CYCLE]
//   b_i       - latched op_b (carry-less multiplicand)
//   base_i    - absolute bit index of a_slice_i[0]
//   clacc_i/o - 64-bit carry-less product accumulator (XOR only)
//   cnt_i/o   - 6-bit count accumulator
//     CLZ : (index of highest set bit) + 1, 0 if none; result is 32 - cnt
//     CTZ : number of zeros seen so far while all lower bits were zero
//     CPOP: running popcount
module bmu_mc_step
  import bmu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [4:0]                option_i,
  input  logic [BITS_PER_CYCLE-1:0] a_slice_i,
  input  logic [31:0]               b_i,
  input  logic [4:0]                base_i,
  input  logic [63:0]               clacc_i,
  input  logic [5:0]                cnt_i,
  output logic [63:0]               clacc_o,
  output logic [5:0]                cnt_o
);

  logic [5:0] idx;

  always_comb begin
    clacc_o = clacc_i;
    cnt_o   = cnt_i;
    idx     = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      idx = {1'b0, base_i} + 6'(k);
      case (option_i)
        OP_CLMUL, OP_CLMULH, OP_CLMULR: begin
          if (a_slice_i[k]) clacc_o = clacc_o ^ ({32'b0, b_i} << idx);
        end
        OP_CLZ: begin
          // Bits arrive LSB first, so the last set bit seen is the highest.
          if (a_slice_i[k]) cnt_o = idx + 6'd1;
        end
        OP_CTZ: begin
          // cnt equals idx only while every lower bit has been zero.
          if (!a_slice_i[k] && (cnt_o == idx)) cnt_o = idx + 6'd1;
        end
        OP_CPOP: begin
          cnt_o = cnt_o + {5'b0, a_slice_i[k]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bmu_mc_unit.sv
// Multi-cycle BMU slice: CLMUL/CLMULH/CLMULR/CLZ/CTZ/CPOP computed over
// 32/BITS_PER_CYCLE RUN cycles with a fixed latency.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - request strobe, only honoured in IDLE
//   option          - 5-bit BMU opcode
//   op_a, op_b      - source operands (op_b used by CLMUL* only)
//   flush           - abort the in-flight operation
//   busy            - high in RUN and DONE
//   stall           - start & idle | RUN
//   done            - one-cycle result-valid pulse
//   result          - operation result, held until the next operation completes
module bmu_mc_unit
  import bmu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  option,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  localparam int         ITERS    = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] CTR_LOAD = 5'(ITERS - 1);
  localparam logic [4:0] POS_STEP = 5'(BITS_PER_CYCLE);

  bmu_state_e  state_q, state_d;
  logic [4:0]  ctr_q;
  logic [4:0]  bitpos_q;
  logic [4:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] clacc_q, clacc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q;
  logic [31:0] final_res;
  logic        accept;

  bmu_mc_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .option_i (op_q),
    .a_slice_i(a_q[bitpos_q +: BITS_PER_CYCLE]),
    .b_i      (b_q),
    .base_i   (bitpos_q),
    .clacc_i  (clacc_q),
    .cnt_i    (cnt_q),
    .clacc_o  (clacc_d),
    .cnt_o    (cnt_d)
  );

  // flush beats start in IDLE
  assign accept = (state_q == ST_IDLE) && start && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = bmu_op_iterates(option) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (flush)              state_d = ST_IDLE;
        else if (ctr_q == 5'd0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Final result from the registered accumulators only; unknown opcodes
  // fall through to zero since their accumulators were cleared at accept.
  always_comb begin
    final_res = '0;
    case (op_q)
      OP_CLMUL:  final_res = clacc_q[31:0];
      OP_CLMULH: final_res = clacc_q[63:32];
      OP_CLMULR: final_res = clacc_q[62:31];
      OP_CLZ:    final_res = {26'b0, 6'd32 - cnt_q};
      OP_CTZ:    final_res = {26'b0, cnt_q};
      OP_CPOP:   final_res = {26'b0, cnt_q};
      default:   final_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ctr_q    <= '0;
      bitpos_q <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      clacc_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= option;
            a_q      <= op_a;
            b_q      <= op_b;
            clacc_q  <= '0;
            cnt_q    <= '0;
            ctr_q    <= CTR_LOAD;
            bitpos_q <= '0;
          end
        end
        ST_RUN: begin
          if (!flush) begin
            clacc_q  <= clacc_d;
            cnt_q    <= cnt_d;
            ctr_q    <= ctr_q - 5'd1;
            bitpos_q <= bitpos_q + POS_STEP;
          end
        end
        ST_DONE: begin
          if (!flush) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign stall  = (start && (state_q == ST_IDLE)) || (state_q == ST_RUN);
  // A flush during DONE cancels the pulse and keeps the previous result.
  assign done   = (state_q == ST_DONE) && !flush;
  assign result = done ? final_res : result_q;

endmodule
